cache_port_arbiter: RTL and testbench

- Shares the single 2-way cache/memory system between the instruction-fetch requester (I) and the data requester (D).
- Accepts one request at a time and presents it to the cache FSM's ld/st/address/data_in_sys inputs.
- Holds those inputs stable until the cache signals done.
- Returns read data and a done pulse to the owning requester. Round-robin arbitration on ties.

---
 rtl/cache_port_arbiter_pkg.sv | 15 +
 rtl/cache_port_arbiter_if.sv | 40 ++++
 rtl/cache_arb_rr.sv | 18 +
 rtl/cache_port_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_cache_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_port_arbiter_pkg.sv
// Shared types for the cache port arbiter: FSM state encoding and requester IDs.
package cache_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_BUSY  = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_e;

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Requester and cache-side bus of the cache port arbiter.
//
// Handshake: i_req/d_req are levels held (with their address/data) until the
// matching one-cycle *_done pulse; *_rdata is valid in the done cycle. On the
// cache side c_ld/c_st/c_addr/c_wdata are held constant until c_done is seen
// high for one cycle, after which c_ld/c_st drop for at least one cycle.
interface cache_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_done;
  logic [DATA_W-1:0] i_rdata;
  logic              d_req;
  logic              d_wr;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_done;
  logic [DATA_W-1:0] d_rdata;
  logic              c_ld;
  logic              c_st;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_done;
  logic [DATA_W-1:0] c_rdata;
  logic              c_hit;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, c_done, c_rdata, c_hit,
    output i_done, i_rdata, d_done, d_rdata, c_ld, c_st, c_addr, c_wdata
  );

  // Requesters plus cache side.
  modport master (
    output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, c_done, c_rdata, c_hit,
    input  i_done, i_rdata, d_done, d_rdata, c_ld, c_st, c_addr, c_wdata
  );
endinterface

// File: rtl/cache_arb_rr.sv
// Two-requester round-robin picker; the last grant is kept by the parent.
module cache_arb_rr
  import cache_port_arbiter_pkg::*;
(
  input  logic    i_req,
  input  logic    d_req,
  input  req_id_e last_grant,
  output logic    grant_d
);

  // A lone requester wins; on a tie the one not granted last time wins.
  always_comb begin
    grant_d = 1'b0;
    if (i_req && d_req) grant_d = (last_grant == REQ_I);
    else                grant_d = d_req;
  end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache between the instruction (I) and data (D) requesters.
// Optional build macro: CACHE_ARB_PERF_CNT_EN adds saturating hit/miss counters.
module cache_port_arbiter
  import cache_port_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst,
  cache_port_arbiter_if.slave bus,
  output logic                grant_d,
  output logic                busy,
  output logic                hang,
  output arb_state_e          dbg_state
`ifdef CACHE_ARB_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]    i_hit_cnt,
  output logic [CNT_W-1:0]    i_miss_cnt,
  output logic [CNT_W-1:0]    d_hit_cnt,
  output logic [CNT_W-1:0]    d_miss_cnt
`endif
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYC);

  arb_state_e        state_q, state_d;
  req_id_e           last_grant_q, last_grant_d;
  logic              grant_d_q, grant_d_d;
  logic              busy_q, busy_d;
  logic              hang_q, hang_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              c_ld_q, c_ld_d, c_st_q, c_st_d;
  logic [ADDR_W-1:0] c_addr_q, c_addr_d;
  logic [DATA_W-1:0] c_wdata_q, c_wdata_d;
  logic              i_done_q, i_done_d, d_done_q, d_done_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              pick_d;
`ifdef CACHE_ARB_PERF_CNT_EN
  logic [CNT_W-1:0]  i_hit_q, i_hit_d, i_miss_q, i_miss_d;
  logic [CNT_W-1:0]  d_hit_q, d_hit_d, d_miss_q, d_miss_d;
`else
  logic              unused_c_hit;
  assign unused_c_hit = bus.c_hit;
`endif

  cache_arb_rr u_rr (
    .i_req      (bus.i_req),
    .d_req      (bus.d_req),
    .last_grant (last_grant_q),
    .grant_d    (pick_d)
  );

  // Next-state and registered-output logic for the IDLE/BUSY/DRAIN FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d_d    = grant_d_q;
    busy_d       = busy_q;
    hang_d       = hang_q;
    tmo_d        = tmo_q;
    c_ld_d       = c_ld_q;
    c_st_d       = c_st_q;
    c_addr_d     = c_addr_q;
    c_wdata_d    = c_wdata_q;
    i_done_d     = 1'b0;
    d_done_d     = 1'b0;
    i_rdata_d    = i_rdata_q;
    d_rdata_d    = d_rdata_q;
`ifdef CACHE_ARB_PERF_CNT_EN
    i_hit_d      = i_hit_q;
    i_miss_d     = i_miss_q;
    d_hit_d      = d_hit_q;
    d_miss_d     = d_miss_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (bus.i_req || bus.d_req) begin
          state_d      = ARB_BUSY;
          busy_d       = 1'b1;
          tmo_d        = '0;
          grant_d_d    = pick_d;
          last_grant_d = pick_d ? REQ_D : REQ_I;
          if (pick_d) begin
            c_addr_d  = bus.d_addr;
            c_wdata_d = bus.d_wdata;
            c_st_d    = bus.d_wr;
            c_ld_d    = ~bus.d_wr;
          end else begin
            c_addr_d  = bus.i_addr;
            c_wdata_d = '0;
            c_st_d    = 1'b0;
            c_ld_d    = 1'b1;
          end
        end
      end
      ARB_BUSY: begin
        // Counter saturates at the limit; hang is sticky until reset.
        if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + 1'b1;
          if ((tmo_q + 1'b1) == TMO_MAX) hang_d = 1'b1;
        end
        if (bus.c_done) begin
          state_d = ARB_DRAIN;
          c_ld_d  = 1'b0;
          c_st_d  = 1'b0;
          if (grant_d_q) begin
            d_done_d = 1'b1;
            if (!c_st_q) d_rdata_d = bus.c_rdata;
          end else begin
            i_done_d  = 1'b1;
            i_rdata_d = bus.c_rdata;
          end
`ifdef CACHE_ARB_PERF_CNT_EN
          if (grant_d_q && bus.c_hit && d_hit_q != {CNT_W{1'b1}})
            d_hit_d = d_hit_q + 1'b1;
          if (grant_d_q && !bus.c_hit && d_miss_q != {CNT_W{1'b1}})
            d_miss_d = d_miss_q + 1'b1;
          if (!grant_d_q && bus.c_hit && i_hit_q != {CNT_W{1'b1}})
            i_hit_d = i_hit_q + 1'b1;
          if (!grant_d_q && !bus.c_hit && i_miss_q != {CNT_W{1'b1}})
            i_miss_d = i_miss_q + 1'b1;
`endif
        end
      end
      ARB_DRAIN: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ARB_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= REQ_I;
      grant_d_q    <= 1'b0;
      busy_q       <= 1'b0;
      hang_q       <= 1'b0;
      tmo_q        <= '0;
      c_ld_q       <= 1'b0;
      c_st_q       <= 1'b0;
      c_addr_q     <= '0;
      c_wdata_q    <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
`ifdef CACHE_ARB_PERF_CNT_EN
      i_hit_q      <= '0;
      i_miss_q     <= '0;
      d_hit_q      <= '0;
      d_miss_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_d_q    <= grant_d_d;
      busy_q       <= busy_d;
      hang_q       <= hang_d;
      tmo_q        <= tmo_d;
      c_ld_q       <= c_ld_d;
      c_st_q       <= c_st_d;
      c_addr_q     <= c_addr_d;
      c_wdata_q    <= c_wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
`ifdef CACHE_ARB_PERF_CNT_EN
      i_hit_q      <= i_hit_d;
      i_miss_q     <= i_miss_d;
      d_hit_q      <= d_hit_d;
      d_miss_q     <= d_miss_d;
`endif
    end
  end

  assign bus.c_ld    = c_ld_q;
  assign bus.c_st    = c_st_q;
  assign bus.c_addr  = c_addr_q;
  assign bus.c_wdata = c_wdata_q;
  assign bus.i_done  = i_done_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_done  = d_done_q;
  assign bus.d_rdata = d_rdata_q;
  assign grant_d     = grant_d_q;
  assign busy        = busy_q;
  assign hang        = hang_q;
  assign dbg_state   = state_q;
`ifdef CACHE_ARB_PERF_CNT_EN
  assign i_hit_cnt   = i_hit_q;
  assign i_miss_cnt  = i_miss_q;
  assign d_hit_cnt   = d_hit_q;
  assign d_miss_cnt  = d_miss_q;
`endif

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with a behavioural cache model.
module tb_cache_port_arbiter;
  import cache_port_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic       grant_d;
  logic       busy;
  logic       hang;
  arb_state_e dbg_state;
`ifdef CACHE_ARB_PERF_CNT_EN
  logic [15:0] i_hit_cnt, i_miss_cnt, d_hit_cnt, d_miss_cnt;
`endif

  cache_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  cache_port_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(64), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .grant_d   (grant_d),
    .busy      (busy),
    .hang      (hang),
    .dbg_state (dbg_state)
`ifdef CACHE_ARB_PERF_CNT_EN
    ,
    .i_hit_cnt (i_hit_cnt),
    .i_miss_cnt(i_miss_cnt),
    .d_hit_cnt (d_hit_cnt),
    .d_miss_cnt(d_miss_cnt)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q[$];  // expected {i_done, d_done} per completed transaction

  // Cache model knobs: m_lat = cycles from request seen to c_done (0 = never).
  int          m_lat = 2;
  logic [15:0] m_data = '0;
  logic        m_hit = 1'b1;
  int          m_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Run until n requester done pulses; optionally drop each req on its done.
  task automatic serve(input int n, input int budget, input bit drop);
    int seen = 0;
    for (int k = 0; k < budget && seen < n; k++) begin
      tick();
      if (bus.i_done) begin
        seen++;
        if (drop) bus.i_req = 1'b0;
      end
      if (bus.d_done) begin
        seen++;
        if (drop) bus.d_req = 1'b0;
      end
    end
    if (!drop) begin
      bus.i_req = 1'b0;
      bus.d_req = 1'b0;
    end
    check("serve_count", seen, n);
  endtask

  // Cache model: counts cycles with c_ld/c_st high and answers with a 1-cycle c_done.
  initial begin
    bus.c_done  = 1'b0;
    bus.c_rdata = '0;
    bus.c_hit   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        m_cnt = 0;
        bus.c_done = 1'b0;
      end else if (bus.c_done) begin
        bus.c_done = 1'b0;
        m_cnt = 0;
      end else if (bus.c_ld || bus.c_st) begin
        m_cnt++;
        if (m_lat != 0 && m_cnt == m_lat) begin
          bus.c_done  = 1'b1;
          bus.c_rdata = m_data;
          bus.c_hit   = m_hit;
        end
      end
    end
  end

  // Scoreboard: every done pulse must match the next expected owner.
  initial begin
    logic [1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (rst && (bus.i_done || bus.d_done)) begin
        if (exp_q.size() == 0) check("done_unexpected", {bus.i_done, bus.d_done}, 2'b00);
        else begin
          e = exp_q.pop_front();
          check("done_owner", {bus.i_done, bus.d_done}, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cd, dd, bad, nb, da, db;
    logic [7:0] pat;

    rst = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_wr = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_hang", hang, 0);
    check("rst_grant", grant_d, 0);
    check("rst_c_ld", bus.c_ld, 0);
    check("rst_c_st", bus.c_st, 0);
    check("rst_c_addr", bus.c_addr, 0);
    check("rst_i_done", bus.i_done, 0);
    check("rst_d_done", bus.d_done, 0);
    check("rst_state", dbg_state, ARB_IDLE);
    rst = 1'b1;
    tick();

    // Single I read, cache hit.
    m_lat = 2; m_hit = 1'b1; m_data = 16'hBEEF;
    bus.i_addr = 16'h1238; bus.i_req = 1'b1;
    exp_q.push_back(2'b10);
    tick();
    check("t1_c_ld", bus.c_ld, 1);
    check("t1_c_st", bus.c_st, 0);
    check("t1_c_addr", bus.c_addr, 16'h1238);
    check("t1_grant", grant_d, 0);
    check("t1_busy", busy, 1);
    tick();
    check("t1_done_c2", bus.i_done, 0);
    tick();
    check("t1_done_c3", bus.i_done, 1);
    check("t1_rdata", bus.i_rdata, 16'hBEEF);
    check("t1_d_done", bus.d_done, 0);
    check("t1_drain_ld", bus.c_ld, 0);
    check("t1_state", dbg_state, ARB_DRAIN);
    bus.i_req = 1'b0;
    tick();
    check("t1_done_c4", bus.i_done, 0);
    check("t1_idle_busy", busy, 0);
    tick();

    // Simultaneous requests held: D, I, D, I.
    m_data = 16'h5A5A;
    bus.i_addr = 16'h0100; bus.d_addr = 16'h0200; bus.d_wr = 1'b0;
    bus.i_req = 1'b1; bus.d_req = 1'b1;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    tick();
    check("t2_first_grant", grant_d, 1);
    check("t2_c_addr", bus.c_addr, 16'h0200);
    check("t2_c_ld", bus.c_ld, 1);
    serve(4, 80, 1'b0);
    tick(); tick();
    check("t2_idle", busy, 0);
    check("t2_d_rdata", bus.d_rdata, 16'h5A5A);
    check("t2_i_rdata", bus.i_rdata, 16'h5A5A);

    // D store, 14-cycle dirty miss.
    m_lat = 14; m_hit = 1'b0; m_data = 16'hFFFF;
    bus.d_wr = 1'b1; bus.d_addr = 16'h8010; bus.d_wdata = 16'h1234; bus.d_req = 1'b1;
    exp_q.push_back(2'b01);
    cd = 0; dd = 0; bad = 0; nb = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (bus.c_done && cd == 0) cd = n;
      if (dbg_state == ARB_BUSY) begin
        nb++;
        if (!(bus.c_st && !bus.c_ld && bus.c_addr == 16'h8010 && bus.c_wdata == 16'h1234))
          bad++;
      end
      if (bus.d_done) begin
        dd = n;
        bus.d_req = 1'b0;
        break;
      end
    end
    check("t3_c_done_cyc", cd, 14);
    check("t3_d_done_cyc", dd, 15);
    check("t3_busy_cycles", nb, 14);
    check("t3_hold_bad", bad, 0);
    check("t3_d_rdata_kept", bus.d_rdata, 16'h5A5A);
    tick();
    check("t3_done_single", bus.d_done, 0);
    bus.d_wr = 1'b0;
    tick();

    // Back-to-back I reads with i_req held.
    m_lat = 2; m_hit = 1'b1; m_data = 16'h1111;
    bus.i_addr = 16'h0040; bus.i_req = 1'b1;
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    pat = '0; da = 0; db = 0;
    for (int n = 1; n <= 8; n++) begin
      tick();
      pat[n-1] = bus.c_ld;
      if (bus.i_done) begin
        if (da == 0) da = n;
        else begin
          db = n;
          bus.i_req = 1'b0;
        end
      end
    end
    check("t4_c_ld_pattern", pat, 8'b0011_0011);
    check("t4_done_a", da, 3);
    check("t4_done_b", db, 7);
    tick();

    // Cache never answers: hang after 64 BUSY cycles, cleared by reset.
    m_lat = 0;
    bus.d_wr = 1'b0; bus.d_addr = 16'h0300; bus.d_req = 1'b1;
    tick();
    check("t5_busy", busy, 1);
    repeat (63) tick();
    check("t5_hang_c64", hang, 0);
    tick();
    check("t5_hang_c65", hang, 1);
    repeat (20) tick();
    check("t5_hang_sticky", hang, 1);
    check("t5_still_busy", busy, 1);
    #3 rst = 1'b0;
    #1;
    check("t5_rst_hang", hang, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_state", dbg_state, ARB_IDLE);
    check("t5_rst_c_ld", bus.c_ld, 0);
    bus.d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-BUSY; afterwards a pending D wins over I.
    m_lat = 10; m_data = 16'h7777;
    bus.i_addr = 16'h0500; bus.i_req = 1'b1;
    tick(); tick(); tick();
    check("t6_busy", busy, 1);
    #3 rst = 1'b0;
    #1;
    check("t6_rst_c_ld", bus.c_ld, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_grant", grant_d, 0);
    check("t6_rst_c_addr", bus.c_addr, 0);
    bus.d_wr = 1'b0; bus.d_addr = 16'h0600; bus.d_req = 1'b1;
    m_lat = 2; m_data = 16'h2222;
    tick();
    rst = 1'b1;
    exp_q.push_back(2'b01); exp_q.push_back(2'b10);
    tick();
    check("t6_grant_d_first", grant_d, 1);
    check("t6_c_addr", bus.c_addr, 16'h0600);
    serve(2, 40, 1'b1);
    tick(); tick();
    check("t6_d_rdata", bus.d_rdata, 16'h2222);
    check("t6_i_rdata", bus.i_rdata, 16'h2222);
    check("t6_idle", busy, 0);

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
